// File: rtl/demux_rr_scheduler_pkg.sv
// Shared definitions for the 1-to-8 demux scheduler and its channel selector.
package demux_rr_scheduler_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return NUM_CH'(1) << s;
  endfunction

endpackage

// File: rtl/demux_rr_scheduler_rr_next_sel.sv
// Combinational channel picker: round-robin after the last grant, or a fixed
// configured channel; reports whether the chosen channel is enabled.
module rr_next_sel
  import demux_rr_scheduler_pkg::*;
(
  input  logic [SEL_W-1:0]  last,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              mode,
  input  logic [SEL_W-1:0]  cfg_sel,
  output logic [SEL_W-1:0]  target,
  output logic              tgt_ok
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    target = '0;
    tgt_ok = 1'b0;
    idx    = '0;
    if (mode == MODE_FIXED) begin
      target = cfg_sel;
      tgt_ok = chan_en[cfg_sel];
    end else begin
      // Walk from the farthest offset down so the nearest enabled channel
      // after last wins; offset NUM_CH wraps back to last itself.
      for (int i = NUM_CH; i >= 1; i--) begin
        idx = last + SEL_W'(i);
        if (chan_en[idx]) begin
          target = idx;
          tgt_ok = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Sequenced 1-to-8 demultiplexer with a registered output word and a
// round-robin or fixed channel selection.
//
// state | meaning
// IDLE  | no word held, out_valid is zero
// HOLD  | one word held for channel sel, waiting on out_ready[sel]
module demux_rr_scheduler
  import demux_rr_scheduler_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [7:0]        chan_en,
  input  logic              mode,
  input  logic [2:0]        cfg_sel,
  output logic [7:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [7:0]        out_ready,
  output logic [2:0]        sel,
  output logic [CNT_W-1:0]  sent_cnt
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;

  logic [SEL_W-1:0]  target;
  logic              tgt_ok;
  logic              deliver;
  logic              accept;

  rr_next_sel u_next_sel (
    .last    (last_q),
    .chan_en (chan_en),
    .mode    (mode),
    .cfg_sel (cfg_sel),
    .target  (target),
    .tgt_ok  (tgt_ok)
  );

  assign deliver  = (state_q == HOLD) && out_ready[sel_q];
  assign in_ready = tgt_ok && ((state_q == IDLE) || deliver);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sent_cnt_d  = sent_cnt_q + {{(CNT_W-1){1'b0}}, deliver};
    case (state_q)
      IDLE: begin
        if (accept) state_d = HOLD;
      end
      HOLD: begin
        if (deliver && !accept) begin
          state_d     = IDLE;
          out_valid_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A same-edge accept replaces the delivered word without a bubble.
    if (accept) begin
      out_data_d  = in_data;
      sel_d       = target;
      out_valid_d = sel_onehot(target);
      last_d      = target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= SEL_W'(NUM_CH - 1);
      sel_q       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      sent_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sent_cnt_q  <= sent_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign sent_cnt  = sent_cnt_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed and randomized bench for demux_rr_scheduler against a
// transaction-level reference model.
module tb_demux_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  chan_en;
  logic        mode;
  logic [2:0]  cfg_sel;
  logic [7:0]  out_valid;
  logic [7:0]  out_data;
  logic [7:0]  out_ready;
  logic [2:0]  sel;
  logic [15:0] sent_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  // reference model: is a word held, for which channel, what word, last grant
  bit          m_hold;
  logic [2:0]  m_sel;
  logic [7:0]  m_data;
  logic [2:0]  m_last;
  logic [15:0] m_cnt;

  demux_rr_scheduler #(.DATA_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .chan_en   (chan_en),
    .mode      (mode),
    .cfg_sel   (cfg_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .sent_cnt  (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Next grant: the lowest enabled channel numbered above the last grant,
  // otherwise the lowest enabled channel overall.
  function automatic void ref_target(input logic [2:0] last, input logic [7:0] en,
                                     input logic md, input logic [2:0] cs,
                                     output logic [2:0] t, output logic ok);
    int lowest;
    int above;
    lowest = -1;
    above  = -1;
    t  = 3'd0;
    ok = 1'b0;
    if (md) begin
      t  = cs;
      ok = en[cs];
    end else begin
      for (int c = 0; c < 8; c++) begin
        if (en[c]) begin
          if (lowest < 0) lowest = c;
          if (above < 0 && c > int'(last)) above = c;
        end
      end
      if (above >= 0) begin
        t = 3'(above); ok = 1'b1;
      end else if (lowest >= 0) begin
        t = 3'(lowest); ok = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    m_hold = 1'b0;
    m_sel  = 3'd0;
    m_data = 8'h00;
    m_last = 3'd7;
    m_cnt  = 16'd0;
  endfunction

  // One clock: entered at a falling edge, drives inputs, checks in_ready
  // before the rising edge and the registered outputs after it.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [7:0] en,
                     input logic md, input logic [2:0] cs, input logic [7:0] rdy,
                     output logic ir_obs);
    logic [2:0] t;
    logic       ok;
    logic       exp_ir;
    logic       acc;
    logic       dlv;
    in_valid  = v;
    in_data   = d;
    chan_en   = en;
    mode      = md;
    cfg_sel   = cs;
    out_ready = rdy;
    #1;
    ref_target(m_last, en, md, cs, t, ok);
    dlv    = m_hold && rdy[m_sel];
    exp_ir = ok && (!m_hold || dlv);
    acc    = v && exp_ir;
    ir_obs = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    @(posedge clk);
    #1;
    if (dlv) m_cnt = m_cnt + 16'd1;
    if (acc) begin
      m_hold = 1'b1; m_sel = t; m_data = d; m_last = t;
    end else if (dlv) begin
      m_hold = 1'b0;
    end
    chk("out_valid", {24'd0, out_valid}, m_hold ? (32'd1 << m_sel) : 32'd0);
    chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    chk("sel", {29'd0, sel}, {29'd0, m_sel});
    chk("sent_cnt", {16'd0, sent_cnt}, {16'd0, m_cnt});
    @(negedge clk);
  endtask

  initial begin : stim
    logic       ir;
    logic [2:0] exp_sel2 [4];
    logic [7:0] exp_ov2  [4];
    logic [7:0] en_r;
    logic [7:0] rdy_r;
    exp_sel2 = '{3'd2, 3'd5, 3'd7, 3'd2};
    exp_ov2  = '{8'h04, 8'h20, 8'h80, 8'h04};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; chan_en = '0;
    mode = 1'b0; cfg_sel = '0; out_ready = '0;
    model_reset();
    @(negedge clk);
    chk("rst_out_valid", {24'd0, out_valid}, 32'h0);
    chk("rst_out_data", {24'd0, out_data}, 32'h0);
    chk("rst_sel", {29'd0, sel}, 32'h0);
    chk("rst_sent_cnt", {16'd0, sent_cnt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin over all channels, back-to-back
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 8'hFF, 1'b0, 3'd0, 8'hFF, ir);
      chk("t1_in_ready", {31'd0, ir}, 32'd1);
      chk("t1_sel", {29'd0, sel}, 32'(i % 8));
      chk("t1_data", {24'd0, out_data}, 32'h10 + 32'(i));
    end
    cyc(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'hFF, ir);
    chk("t1_cnt", {16'd0, sent_cnt}, 32'd10);

    // Sparse mask
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h20 + 8'(i), 8'b1010_0100, 1'b0, 3'd0, 8'hFF, ir);
      chk("t2_sel", {29'd0, sel}, {29'd0, exp_sel2[i]});
      chk("t2_ov", {24'd0, out_valid}, {24'd0, exp_ov2[i]});
    end
    cyc(1'b0, 8'h00, 8'b1010_0100, 1'b0, 3'd0, 8'hFF, ir);

    // Backpressure on channel 3
    cyc(1'b1, 8'hAA, 8'hFF, 1'b0, 3'd0, 8'hF7, ir);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h5A, 8'hFF, 1'b0, 3'd0, 8'hF7, ir);
      chk("t3_in_ready", {31'd0, ir}, 32'd0);
      chk("t3_ov", {24'd0, out_valid}, 32'h08);
      chk("t3_data", {24'd0, out_data}, 32'hAA);
      chk("t3_cnt_hold", {16'd0, sent_cnt}, 32'd14);
    end
    cyc(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'hFF, ir);
    chk("t3_cnt", {16'd0, sent_cnt}, 32'd15);

    // Fixed mode, then target disabled
    cyc(1'b1, 8'h3C, 8'hFF, 1'b1, 3'd6, 8'hFF, ir);
    chk("t4_ov", {24'd0, out_valid}, 32'h40);
    cyc(1'b1, 8'h3D, 8'hBF, 1'b1, 3'd6, 8'hFF, ir);
    chk("t4_in_ready_dis", {31'd0, ir}, 32'd0);
    cyc(1'b1, 8'h3E, 8'hBF, 1'b1, 3'd6, 8'hFF, ir);
    chk("t4_in_ready_dis2", {31'd0, ir}, 32'd0);
    chk("t4_idle_ov", {24'd0, out_valid}, 32'h0);

    // Mask change while holding on channel 1
    cyc(1'b1, 8'h55, 8'h02, 1'b0, 3'd0, 8'h00, ir);
    chk("t5_sel_held", {29'd0, sel}, 32'd1);
    cyc(1'b0, 8'h00, 8'h01, 1'b0, 3'd0, 8'h00, ir);
    chk("t5_still_ch1", {24'd0, out_valid}, 32'h02);
    cyc(1'b1, 8'h66, 8'h01, 1'b0, 3'd0, 8'h02, ir);
    chk("t5_next_ch0", {24'd0, out_valid}, 32'h01);
    chk("t5_next_data", {24'd0, out_data}, 32'h66);
    cyc(1'b0, 8'h00, 8'h01, 1'b0, 3'd0, 8'hFF, ir);

    // Async reset while a word is held
    cyc(1'b1, 8'h77, 8'hFF, 1'b0, 3'd0, 8'h00, ir);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_ov", {24'd0, out_valid}, 32'h0);
    chk("t6_sel", {29'd0, sel}, 32'h0);
    chk("t6_cnt", {16'd0, sent_cnt}, 32'h0);
    chk("t6_data", {24'd0, out_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h88, 8'hFF, 1'b0, 3'd0, 8'hFF, ir);
    chk("t6_first_ch0", {29'd0, sel}, 32'd0);

    // Randomized traffic with mode, mask and ready churn
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: en_r = 8'hFF;
        1: en_r = 8'd1 << $urandom_range(0, 7);
        2: en_r = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
        default: en_r = 8'($urandom);
      endcase
      rdy_r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), en_r,
          1'($urandom_range(0, 4) == 0), 3'($urandom), rdy_r, ir);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
